// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the multiplexed-bus RTC read sequencer:
// FSM encoding, bus level bundle and default phase timings.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    GAP  = 3'd2,
    RD   = 3'd3,
    REC  = 3'd4,
    DONE = 3'd5,
    WAIT = 3'd6
  } state_t;

  typedef struct packed {
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d_n;
  } bus_t;

  localparam bus_t BUS_IDLE = '{
    ad_out: 8'h00,
    ad_oe:  1'b0,
    cs_n:   1'b1,
    rd_n:   1'b1,
    wr_n:   1'b1,
    a_d_n:  1'b1
  };

  localparam int T_ADDR_DEF = 4;
  localparam int T_GAP_DEF  = 2;
  localparam int T_RD_DEF   = 6;
  localparam int T_REC_DEF  = 4;
  localparam int CW_DEF     = 4;

  // Pad/strobe levels driven while the FSM sits in state s.
  function automatic bus_t bus_levels(state_t s, logic [7:0] addr);
    bus_t b;
    b = BUS_IDLE;
    case (s)
      ADDR: begin
        b.ad_out = addr;
        b.ad_oe  = 1'b1;
        b.a_d_n  = 1'b0;
        b.cs_n   = 1'b0;
        b.wr_n   = 1'b0;
      end
      RD: begin
        b.cs_n = 1'b0;
        b.rd_n = 1'b0;
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/temporizador_fase.sv
// Loadable down-counter timing each bus phase; saturates at zero.
module temporizador_fase #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          zero
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/secuenciador_bus_rtc.sv
// RTC multiplexed-bus read sequencer: address write, turnaround gap, data
// read, recovery, then a one-cycle fin pulse back to the read controller.
module secuenciador_bus_rtc
  import rtc_bus_pkg::*;
#(
  parameter int T_ADDR = T_ADDR_DEF,
  parameter int T_GAP  = T_GAP_DEF,
  parameter int T_RD   = T_RD_DEF,
  parameter int T_REC  = T_REC_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       activa,
  input  logic [7:0] dir,
  input  logic [7:0] dato_bus_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d_n,
  output logic [7:0] dato_leido,
  output logic       fin
);

  state_t        state, state_next;
  logic [7:0]    dir_q, dir_q_next;
  logic          cnt_load, cnt_en, cnt_zero;
  logic [CW-1:0] cnt_val, cnt_count;
  logic          dato_latch;
  bus_t          bus_q, bus_next;
  logic          fin_q;
  logic [7:0]    dato_q;

  temporizador_fase #(.CW(CW)) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .enable   (cnt_en),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    dir_q_next = dir_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_en     = 1'b0;
    dato_latch = 1'b0;
    case (state)
      IDLE: begin
        if (activa) begin
          state_next = ADDR;
          dir_q_next = dir;
          cnt_load   = 1'b1;
          cnt_val    = CW'(T_ADDR - 1);
        end
      end
      ADDR: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_next = GAP;
          cnt_load   = 1'b1;
          cnt_val    = CW'(T_GAP - 1);
        end
      end
      GAP: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_next = RD;
          cnt_load   = 1'b1;
          cnt_val    = CW'(T_RD - 1);
        end
      end
      RD: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_next = REC;
          dato_latch = 1'b1;
          cnt_load   = 1'b1;
          cnt_val    = CW'(T_REC - 1);
        end
      end
      REC: begin
        cnt_en = 1'b1;
        if (cnt_zero) state_next = DONE;
      end
      DONE: state_next = WAIT;
      WAIT: if (!activa) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Outputs are decoded from the next state so the registered pins line up
    // with the state they belong to.
    bus_next = bus_levels(state_next, dir_q_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      dir_q  <= '0;
      bus_q  <= BUS_IDLE;
      fin_q  <= 1'b0;
      dato_q <= '0;
    end else begin
      state <= state_next;
      dir_q <= dir_q_next;
      bus_q <= bus_next;
      fin_q <= (state_next == DONE);
      if (dato_latch) dato_q <= dato_bus_in;
    end
  end

  assign ad_out     = bus_q.ad_out;
  assign ad_oe      = bus_q.ad_oe;
  assign cs_n       = bus_q.cs_n;
  assign rd_n       = bus_q.rd_n;
  assign wr_n       = bus_q.wr_n;
  assign a_d_n      = bus_q.a_d_n;
  assign dato_leido = dato_q;
  assign fin        = fin_q;

endmodule

// File: tb/tb_secuenciador_bus_rtc.sv
// Directed bench for secuenciador_bus_rtc: per-cycle bus profile against a
// cycle-indexed reference, read data scoreboarded from request to fin.
module tb_secuenciador_bus_rtc;

  logic       clk = 1'b0;
  logic       reset;
  logic       activa;
  logic [7:0] dir;
  logic [7:0] dato_bus_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d_n;
  logic [7:0] dato_leido;
  logic       fin;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb[$];

  // {fin, cs_n, rd_n, wr_n, a_d_n, ad_oe, ad_out}
  localparam logic [13:0] IDLE_LV = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
  logic [13:0] obs;
  assign obs = {fin, cs_n, rd_n, wr_n, a_d_n, ad_oe, ad_out};

  secuenciador_bus_rtc dut (
    .clk         (clk),
    .reset       (reset),
    .activa      (activa),
    .dir         (dir),
    .dato_bus_in (dato_bus_in),
    .ad_out      (ad_out),
    .ad_oe       (ad_oe),
    .cs_n        (cs_n),
    .rd_n        (rd_n),
    .wr_n        (wr_n),
    .a_d_n       (a_d_n),
    .dato_leido  (dato_leido),
    .fin         (fin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pins k edges after the edge that sampled activa in IDLE
  // (default timing: 4 address, 2 gap, 6 read, 4 recovery cycles).
  function automatic logic [13:0] exp_bus(int k, logic [7:0] d);
    if (k < 4)   return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, d};
    if (k < 6)   return IDLE_LV;
    if (k < 12)  return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    if (k == 16) return {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    return IDLE_LV;
  endfunction

  // Protocol invariants sampled every cycle outside reset.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("oe_vs_rd", 32'(ad_oe & ~rd_n), 32'd0);
      check("wr_vs_ad", 32'(~wr_n & a_d_n), 32'd0);
    end
  end

  task automatic run_txn(input logic [7:0] d, input logic [7:0] data,
                         input int drop_k, input int hold);
    logic [7:0] exp_dato;
    dir         = d;
    activa      = 1'b1;
    dato_bus_in = ~data;
    sb.push_back(data);
    for (int k = 0; k < 18; k++) begin
      tick();
      check($sformatf("bus_k%0d_dir%h", k, d), 32'(obs), 32'(exp_bus(k, d)));
      if (fin && sb.size() != 0) begin
        exp_dato = sb.pop_front();
        check("dato_leido_at_fin", 32'(dato_leido), 32'(exp_dato));
      end
      if (k == 0)      dir = ~d;
      if (k == 11)     dato_bus_in = data;
      if (k == 12)     dato_bus_in = ~data;
      if (k == drop_k) activa = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("wait_hold_idle", 32'(obs), 32'(IDLE_LV));
    end
    activa = 1'b0;
    tick();
    check("release_idle", 32'(obs), 32'(IDLE_LV));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("dato_leido_hold", 32'(dato_leido), 32'(data));
  endtask

  initial begin
    reset       = 1'b1;
    activa      = 1'b0;
    dir         = 8'h00;
    dato_bus_in = 8'h00;
    tick();
    tick();
    check("reset_bus", 32'(obs), 32'(IDLE_LV));
    check("reset_dato", 32'(dato_leido), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_no_request", 32'(obs), 32'(IDLE_LV));
    end

    // Basic read, then activa held high through WAIT for 10 cycles.
    run_txn(8'h21, 8'h59, -1, 10);
    // Fresh request after a single low cycle.
    run_txn(8'h7E, 8'hC3, -1, 0);
    // activa dropped in the third RD cycle; read still completes.
    run_txn(8'h05, 8'hA6, 8, 0);

    // Reset during the address phase aborts without fin.
    dir    = 8'hA5;
    activa = 1'b1;
    tick();
    check("abort_addr_entry", 32'(obs), 32'(exp_bus(0, 8'hA5)));
    tick();
    reset  = 1'b1;
    activa = 1'b0;
    tick();
    check("abort_idle", 32'(obs), 32'(IDLE_LV));
    check("abort_dato_cleared", 32'(dato_leido), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("abort_no_fin", 32'(obs), 32'(IDLE_LV));
    end

    run_txn(8'hF0, 8'h3C, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
